// File: rtl/data_mem_responder.sv
// Single-port data memory responder: latches a CPU load/store request, waits WAIT_CYC
// cycles, performs one array access with RISC-V size/sign handling, then pulses ack.
module data_mem_responder #(
    parameter int ADDR_W   = 8,
    parameter int WAIT_CYC = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [2:0]  lcode,
    output logic        ack,
    output logic [31:0] rdata,
    output logic        err,
    output logic        busy,
    output logic [1:0]  dbg_state_o
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [3:0] WAIT_LOAD = (WAIT_CYC > 0) ? 4'(WAIT_CYC - 1) : 4'd0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                we_q, we_d;
    logic [ADDR_W+1:0]   addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [2:0]          lcode_q, lcode_d;
    logic [31:0]         rdata_q, rdata_d;
    logic                err_q, err_d;

    // Contents start at zero and are deliberately outside the reset domain.
    logic [31:0] mem_q [DEPTH] = '{default: 32'h0};

    logic [ADDR_W-1:0] idx_c;
    logic [31:0]       word_c;
    logic [7:0]        byte_c;
    logic [15:0]       half_c;
    logic [31:0]       load_c;
    logic [31:0]       merge_c;
    logic              err_c;
    logic              wr_en_c;

    assign idx_c  = addr_q[ADDR_W+1:2];
    assign word_c = mem_q[idx_c];
    assign byte_c = word_c[{addr_q[1:0], 3'b000} +: 8];
    assign half_c = addr_q[1] ? word_c[31:16] : word_c[15:0];

    always_comb begin
        err_c = 1'b0;
        if (lcode_q[1:0] == 2'b11 || lcode_q == 3'b110) err_c = 1'b1;
        if (lcode_q[1:0] == 2'b01 && addr_q[0]) err_c = 1'b1;
        if (lcode_q[1:0] == 2'b10 && addr_q[1:0] != 2'b00) err_c = 1'b1;
        if (we_q && lcode_q[2]) err_c = 1'b1;
    end

    always_comb begin
        load_c = 32'h0;
        case (lcode_q)
            3'b000:  load_c = {{24{byte_c[7]}}, byte_c};
            3'b001:  load_c = {{16{half_c[15]}}, half_c};
            3'b010:  load_c = word_c;
            3'b100:  load_c = {24'h0, byte_c};
            3'b101:  load_c = {16'h0, half_c};
            default: load_c = 32'h0;
        endcase
    end

    // Read-modify-write merge: unselected lanes keep their current contents.
    always_comb begin
        merge_c = word_c;
        case (lcode_q[1:0])
            2'b00: merge_c[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
            2'b01: begin
                if (addr_q[1]) merge_c[31:16] = wdata_q[15:0];
                else           merge_c[15:0]  = wdata_q[15:0];
            end
            2'b10:   merge_c = wdata_q;
            default: merge_c = word_c;
        endcase
    end

    assign wr_en_c = (state_q == ACCESS) && we_q && !err_c && !rst;

    always_ff @(posedge clk) begin
        if (wr_en_c) mem_q[idx_c] <= merge_c;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        lcode_d = lcode_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    we_d    = we;
                    addr_d  = addr[ADDR_W+1:0];
                    wdata_d = wdata;
                    lcode_d = lcode;
                    if (WAIT_CYC > 0) begin
                        state_d = WAIT;
                        cnt_d   = WAIT_LOAD;
                    end else begin
                        state_d = ACCESS;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) state_d = ACCESS;
                else               cnt_d   = cnt_q - 4'd1;
            end
            ACCESS: begin
                err_d   = err_c;
                rdata_d = (err_c || we_q) ? 32'h0 : load_c;
                state_d = RESP;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 32'h0;
            lcode_q <= 3'b000;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            lcode_q <= lcode_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign ack         = (state_q == RESP);
    assign busy        = (state_q != IDLE);
    assign rdata       = rdata_q;
    assign err         = err_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: one instance with WAIT_CYC=1 for the
// functional scenarios and one with WAIT_CYC=0 for back-to-back throughput.
module tb_data_mem_responder;

    logic        clk;
    logic        rst;
    logic        req, we;
    logic [31:0] addr, wdata;
    logic [2:0]  lcode;
    logic        ack, err, busy;
    logic [31:0] rdata;
    logic [1:0]  dbg_state;

    logic        req0, we0;
    logic [31:0] addr0, wdata0;
    logic [2:0]  lcode0;
    logic        ack0, err0, busy0;
    logic [31:0] rdata0;
    logic [1:0]  dbg_state0;

    int n_vec;
    int n_bad;

    localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010, LBU = 3'b100, LHU = 3'b101;

    data_mem_responder #(.ADDR_W(8), .WAIT_CYC(1)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .lcode(lcode), .ack(ack), .rdata(rdata), .err(err), .busy(busy),
        .dbg_state_o(dbg_state)
    );

    data_mem_responder #(.ADDR_W(8), .WAIT_CYC(0)) dut0 (
        .clk(clk), .rst(rst), .req(req0), .we(we0), .addr(addr0), .wdata(wdata0),
        .lcode(lcode0), .ack(ack0), .rdata(rdata0), .err(err0), .busy(busy0),
        .dbg_state_o(dbg_state0)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Issues one request from IDLE, counts edges up to ack, then lets the DUT return to IDLE.
    task automatic access(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [2:0] lc, output logic [31:0] rd,
                          output logic e, output int lat);
        we = w; addr = a; wdata = d; lcode = lc; req = 1'b1;
        lat = 0;
        rd  = 32'h0;
        e   = 1'b0;
        while (lat < 20) begin
            @(posedge clk); #1;
            lat++;
            if (ack) break;
        end
        if (!ack) lat = -1;
        rd  = rdata;
        e   = err;
        req = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_vec++; if (ack !== 1'b0) begin n_bad++; $display("FAIL reset_ack got %b want 0", ack); end
        n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
        n_vec++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err got %b want 0", err); end
        n_vec++; if (rdata !== 32'h0) begin n_bad++; $display("FAIL reset_rdata got %h want 00000000", rdata); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_word();
        logic [31:0] rd; logic e; int lat;
        access(1'b1, 32'h10, 32'hDEADBEEF, LW, rd, e, lat);
        n_vec++; if (lat !== 3) begin n_bad++; $display("FAIL sw_latency got %0d want 3", lat); end
        n_vec++; if (rd !== 32'h0 || e !== 1'b0) begin n_bad++; $display("FAIL sw_resp got %h/%b want 00000000/0", rd, e); end
        n_vec++; if (ack !== 1'b0) begin n_bad++; $display("FAIL ack_single got %b want 0", ack); end
        access(1'b0, 32'h10, 32'h0, LW, rd, e, lat);
        n_vec++; if (lat !== 3) begin n_bad++; $display("FAIL lw_latency got %0d want 3", lat); end
        n_vec++; if (rd !== 32'hDEADBEEF || e !== 1'b0) begin n_bad++; $display("FAIL lw_10 got %h/%b want deadbeef/0", rd, e); end
        n_vec++; if (rdata !== 32'hDEADBEEF) begin n_bad++; $display("FAIL rdata_hold got %h want deadbeef", rdata); end
    endtask

    task automatic test_byte();
        logic [31:0] rd; logic e; int lat;
        access(1'b1, 32'h11, 32'h000000A5, LB, rd, e, lat);
        access(1'b0, 32'h10, 32'h0, LW, rd, e, lat);
        n_vec++; if (rd !== 32'hDEADA5EF) begin n_bad++; $display("FAIL sb_lw got %h want deada5ef", rd); end
        access(1'b0, 32'h11, 32'h0, LB, rd, e, lat);
        n_vec++; if (rd !== 32'hFFFFFFA5) begin n_bad++; $display("FAIL lb_11 got %h want ffffffa5", rd); end
        access(1'b0, 32'h11, 32'h0, LBU, rd, e, lat);
        n_vec++; if (rd !== 32'h000000A5) begin n_bad++; $display("FAIL lbu_11 got %h want 000000a5", rd); end
        access(1'b0, 32'h13, 32'h0, LBU, rd, e, lat);
        n_vec++; if (rd !== 32'h000000DE) begin n_bad++; $display("FAIL lbu_13 got %h want 000000de", rd); end
    endtask

    task automatic test_half();
        logic [31:0] rd; logic e; int lat;
        access(1'b1, 32'h22, 32'h00008001, LH, rd, e, lat);
        access(1'b0, 32'h22, 32'h0, LH, rd, e, lat);
        n_vec++; if (rd !== 32'hFFFF8001) begin n_bad++; $display("FAIL lh_22 got %h want ffff8001", rd); end
        access(1'b0, 32'h22, 32'h0, LHU, rd, e, lat);
        n_vec++; if (rd !== 32'h00008001) begin n_bad++; $display("FAIL lhu_22 got %h want 00008001", rd); end
        access(1'b0, 32'h20, 32'h0, LW, rd, e, lat);
        n_vec++; if (rd !== 32'h80010000) begin n_bad++; $display("FAIL lw_20 got %h want 80010000", rd); end
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic e; int lat;
        access(1'b0, 32'h13, 32'h0, LW, rd, e, lat);
        n_vec++; if (e !== 1'b1 || rd !== 32'h0 || lat !== 3) begin n_bad++; $display("FAIL lw_mis got %b/%h/%0d want 1/00000000/3", e, rd, lat); end
        access(1'b1, 32'h15, 32'h0000FFFF, LH, rd, e, lat);
        n_vec++; if (e !== 1'b1 || rd !== 32'h0) begin n_bad++; $display("FAIL sh_mis got %b/%h want 1/00000000", e, rd); end
        access(1'b1, 32'h10, 32'hFFFFFFFF, LBU, rd, e, lat);
        n_vec++; if (e !== 1'b1) begin n_bad++; $display("FAIL sbu_err got %b want 1", e); end
        access(1'b0, 32'h10, 32'h0, 3'b011, rd, e, lat);
        n_vec++; if (e !== 1'b1 || rd !== 32'h0) begin n_bad++; $display("FAIL lcode011 got %b/%h want 1/00000000", e, rd); end
        access(1'b0, 32'h14, 32'h0, LW, rd, e, lat);
        n_vec++; if (rd !== 32'h0 || e !== 1'b0) begin n_bad++; $display("FAIL mem_14 got %h/%b want 00000000/0", rd, e); end
        access(1'b0, 32'h10, 32'h0, LW, rd, e, lat);
        n_vec++; if (rd !== 32'hDEADA5EF) begin n_bad++; $display("FAIL mem_10 got %h want deada5ef", rd); end
    endtask

    task automatic test_wrap();
        logic [31:0] rd; logic e; int lat;
        access(1'b1, 32'h00000440, 32'hCAFEF00D, LW, rd, e, lat);
        access(1'b0, 32'h00000040, 32'h0, LW, rd, e, lat);
        n_vec++; if (rd !== 32'hCAFEF00D) begin n_bad++; $display("FAIL wrap got %h want cafef00d", rd); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; logic e; int lat;
        int acks;
        we = 1'b1; addr = 32'h30; wdata = 32'h12345678; lcode = LW; req = 1'b1;
        @(posedge clk); #1;
        req = 1'b0;
        n_vec++; if (busy !== 1'b1) begin n_bad++; $display("FAIL mid_busy got %b want 1", busy); end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL mid_idle got %b want 0", busy); end
        acks = 0;
        repeat (5) begin
            if (ack) acks++;
            @(posedge clk); #1;
        end
        n_vec++; if (acks !== 0) begin n_bad++; $display("FAIL mid_noack got %0d want 0", acks); end
        access(1'b0, 32'h30, 32'h0, LW, rd, e, lat);
        n_vec++; if (rd !== 32'h0) begin n_bad++; $display("FAIL mid_mem got %h want 00000000", rd); end
        // Request held through reset release is taken on the first IDLE edge.
        rst = 1'b1; we = 1'b0; addr = 32'h10; lcode = LW; req = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        lat = 0;
        while (lat < 20) begin
            @(posedge clk); #1;
            lat++;
            if (ack) break;
        end
        n_vec++; if (lat !== 3 || rdata !== 32'hDEADA5EF) begin n_bad++; $display("FAIL rst_release got %0d/%h want 3/deada5ef", lat, rdata); end
        req = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int cyc;
        int ack_at[3];
        int n;
        we0 = 1'b0; addr0 = 32'h8; wdata0 = 32'h0; lcode0 = LW; req0 = 1'b1;
        n = 0;
        cyc = 0;
        while (n < 3 && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
            if (ack0) begin
                ack_at[n] = cyc;
                n++;
            end
        end
        req0 = 1'b0;
        n_vec++; if (n !== 3) begin n_bad++; $display("FAIL b2b_count got %0d want 3", n); end
        if (n == 3) begin
            n_vec++; if (ack_at[0] !== 2) begin n_bad++; $display("FAIL b2b_first got %0d want 2", ack_at[0]); end
            n_vec++; if (ack_at[1] - ack_at[0] !== 3) begin n_bad++; $display("FAIL b2b_gap1 got %0d want 3", ack_at[1] - ack_at[0]); end
            n_vec++; if (ack_at[2] - ack_at[1] !== 3) begin n_bad++; $display("FAIL b2b_gap2 got %0d want 3", ack_at[2] - ack_at[1]); end
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        n_vec = 0; n_bad = 0;
        rst = 1'b1;
        req = 1'b0; we = 1'b0; addr = 32'h0; wdata = 32'h0; lcode = 3'b000;
        req0 = 1'b0; we0 = 1'b0; addr0 = 32'h0; wdata0 = 32'h0; lcode0 = 3'b000;
        @(posedge clk); #1;
        test_reset();
        test_word();
        test_byte();
        test_half();
        test_errors();
        test_wrap();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
